// File: rtl/axi_lite_master_if.sv
// AXI-Lite bus between one initiator (master modport) and one target (slave modport).
interface axi_lite_master_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-Lite initiator turning sequencer commands into bus transactions.
// Optional watchdog abort compiled in with AXIL_MASTER_TIMEOUT_EN.
module axi_lite_master #(
  parameter int unsigned ADDR_W         = 5,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_is_read,
  output logic                rsp_timeout,
  axi_lite_master_if.master   m_axi
);
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;
  logic                rsp_is_read_q, rsp_is_read_d;

  logic cmd_hs_c, aw_hs_c, w_hs_c, b_hs_c, ar_hs_c, r_hs_c;

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
    $error("axi_lite_master: TIMEOUT_CYCLES must be at least 2");
  end

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             write_q, write_d;
  logic             rsp_timeout_q, rsp_timeout_d;
  logic             active_c;
`endif

  assign cmd_hs_c = cmd_valid & cmd_ready_q;
  assign aw_hs_c  = awvalid_q & m_axi.awready;
  assign w_hs_c   = wvalid_q & m_axi.wready;
  assign b_hs_c   = bready_q & m_axi.bvalid;
  assign ar_hs_c  = arvalid_q & m_axi.arready;
  assign r_hs_c   = rready_q & m_axi.rvalid;

  // Next-state and next-output logic for every registered output
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_is_read_d = rsp_is_read_q;
    cmd_ready_d   = cmd_ready_q;
`ifdef AXIL_MASTER_TIMEOUT_EN
    cnt_d         = cnt_q;
    write_d       = write_q;
    rsp_timeout_d = rsp_timeout_q;
    active_c      = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (cmd_hs_c) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end
      WR: begin
        // AW and W complete independently; each valid drops right after its own handshake
        if (aw_hs_c) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs_c) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q | aw_hs_c) & (w_done_q | w_hs_c)) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (b_hs_c) begin
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_resp_d    = m_axi.bresp;
          rsp_rdata_d   = '0;
          rsp_is_read_d = 1'b0;
          state_d       = RSP;
        end
      end
      RD_ADDR: begin
        if (ar_hs_c) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (r_hs_c) begin
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_resp_d    = m_axi.rresp;
          rsp_rdata_d   = m_axi.rdata;
          rsp_is_read_d = 1'b1;
          state_d       = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef AXIL_MASTER_TIMEOUT_EN
    // Watchdog: abort the bus phase and report SLVERR; late B/R are ignored since readies drop
    active_c = (state_q == WR) || (state_q == WR_RESP) ||
               (state_q == RD_ADDR) || (state_q == RD_DATA);
    if (state_q == IDLE) begin
      cnt_d = '0;
      if (cmd_hs_c) begin
        write_d       = cmd_write;
        rsp_timeout_d = 1'b0;
      end
    end else if (active_c) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        awvalid_d     = 1'b0;
        wvalid_d      = 1'b0;
        bready_d      = 1'b0;
        arvalid_d     = 1'b0;
        rready_d      = 1'b0;
        rsp_valid_d   = 1'b1;
        rsp_resp_d    = RESP_SLVERR;
        rsp_rdata_d   = '0;
        rsp_is_read_d = ~write_q;
        rsp_timeout_d = 1'b1;
        state_d       = RSP;
      end
    end
`endif

    cmd_ready_d = (state_d == IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      rsp_is_read_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_is_read_q <= rsp_is_read_d;
    end
  end

`ifdef AXIL_MASTER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      write_q       <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      write_q       <= write_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_is_read   = rsp_is_read_q;
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;
endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master with a small AXI-Lite register-file slave model.
module tb_axi_lite_master;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TO_CYC = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic [3:0]        cmd_wstrb = '0;
  logic              rsp_valid, rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_resp;
  logic              rsp_is_read, rsp_timeout;

  int vectors = 0;
  int miscompares = 0;

  axi_lite_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

  axi_lite_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_is_read(rsp_is_read), .rsp_timeout(rsp_timeout),
    .m_axi(axi)
  );

  always #5 clk = ~clk;

  // Slave knobs
  int         aw_lat = 1;
  logic       ar_block = 1'b0;
  logic       r_hold = 1'b0;
  logic [1:0] b_resp_cfg = 2'b00;

  int                aw_wait;
  logic [31:0]       regs [8];
  logic              s_have_aw, s_have_w, s_b_pend, s_r_pend;
  logic [ADDR_W-1:0] s_awaddr, s_araddr;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wstrb;

  assign axi.awready = axi.awvalid && (aw_wait + 1 >= aw_lat);
  assign axi.wready  = 1'b1;
  assign axi.arready = !ar_block;

  // Slave: responds the cycle after it sees the master's bready/rready
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      regs[4]    <= 32'h20260116;
      aw_wait    <= 0;
      s_have_aw  <= 1'b0;
      s_have_w   <= 1'b0;
      s_b_pend   <= 1'b0;
      s_r_pend   <= 1'b0;
      s_awaddr   <= '0;
      s_araddr   <= '0;
      s_wdata    <= '0;
      s_wstrb    <= '0;
      axi.bvalid <= 1'b0;
      axi.bresp  <= 2'b00;
      axi.rvalid <= 1'b0;
      axi.rdata  <= '0;
      axi.rresp  <= 2'b00;
    end else begin
      if (axi.awvalid && !axi.awready) aw_wait <= aw_wait + 1;
      else aw_wait <= 0;
      if (axi.awvalid && axi.awready) begin
        s_have_aw <= 1'b1;
        s_awaddr  <= axi.awaddr;
      end
      if (axi.wvalid && axi.wready) begin
        s_have_w <= 1'b1;
        s_wdata  <= axi.wdata;
        s_wstrb  <= axi.wstrb;
      end
      if (s_have_aw && s_have_w) begin
        for (int b = 0; b < 4; b++)
          if (s_wstrb[b]) regs[s_awaddr[4:2]][8*b +: 8] <= s_wdata[8*b +: 8];
        s_have_aw <= 1'b0;
        s_have_w  <= 1'b0;
        s_b_pend  <= 1'b1;
      end
      if (s_b_pend && axi.bready && !axi.bvalid) begin
        axi.bvalid <= 1'b1;
        axi.bresp  <= b_resp_cfg;
      end
      if (axi.bvalid && axi.bready) begin
        axi.bvalid <= 1'b0;
        s_b_pend   <= 1'b0;
      end
      if (axi.arvalid && axi.arready) begin
        s_r_pend <= 1'b1;
        s_araddr <= axi.araddr;
      end
      if (s_r_pend && axi.rready && !axi.rvalid && !r_hold) begin
        axi.rvalid <= 1'b1;
        axi.rdata  <= regs[s_araddr[4:2]];
        axi.rresp  <= 2'b00;
      end
      if (axi.rvalid && axi.rready) begin
        axi.rvalid <= 1'b0;
        s_r_pend   <= 1'b0;
      end
    end
  end

  // Bus activity monitor
  int aw_hi = 0, w_hi = 0, ar_hi = 0, aw_hs_n = 0, w_hs_n = 0;
  logic [ADDR_W-1:0] aw_log [$];
  always @(posedge clk) begin
    if (axi.awvalid) aw_hi++;
    if (axi.wvalid) w_hi++;
    if (axi.arvalid) ar_hi++;
    if (axi.awvalid && axi.awready) begin
      aw_hs_n++;
      aw_log.push_back(axi.awaddr);
    end
    if (axi.wvalid && axi.wready) w_hs_n++;
  end

  // Issue one command; lat = cycles from cmd handshake to first rsp_valid, -1 when no response arrives
  task automatic send_cmd(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic [3:0] s, input int max_cycles, output int lat);
    int  n;
    bit  done;
    lat = -1;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cmd_ready !== 1'b1 && n < 50);
    if (cmd_ready === 1'b1) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      n = 1;
      done = 1'b0;
      while (!done && n <= max_cycles) begin
        @(negedge clk);
        if (rsp_valid === 1'b1) begin
          lat  = n;
          done = 1'b1;
        end
        n++;
      end
    end else begin
      cmd_valid = 1'b0;
    end
  endtask

  task automatic consume_rsp();
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    vectors++; if ({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready} !== 5'b0) begin
      miscompares++; $display("FAIL reset_axi_valids: got %b expected 00000",
                              {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    vectors++; if ({rsp_rdata, rsp_resp, rsp_is_read, rsp_timeout} !== 36'h0) begin
      miscompares++; $display("FAIL reset_rsp_fields: got %h expected 0", {rsp_rdata, rsp_resp, rsp_is_read, rsp_timeout}); end
  endtask

  task automatic test_read();
    int lat;
    send_cmd(1'b0, 5'h10, '0, 4'h0, 20, lat);
    vectors++; if (lat !== 4) begin miscompares++; $display("FAIL read_latency: got %0d expected 4", lat); end
    vectors++; if (rsp_rdata !== 32'h20260116) begin miscompares++; $display("FAIL read_rdata: got %h expected 20260116", rsp_rdata); end
    vectors++; if (rsp_resp !== 2'b00) begin miscompares++; $display("FAIL read_resp: got %b expected 00", rsp_resp); end
    vectors++; if (rsp_is_read !== 1'b1) begin miscompares++; $display("FAIL read_is_read: got %b expected 1", rsp_is_read); end
    vectors++; if (rsp_timeout !== 1'b0) begin miscompares++; $display("FAIL read_timeout: got %b expected 0", rsp_timeout); end
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL read_cmd_stall: got %b expected 0", cmd_ready); end
    consume_rsp();
  endtask

  task automatic test_write_aw_delay();
    int lat, a0, w0, ah0, wh0;
    a0 = aw_hi; w0 = w_hi; ah0 = aw_hs_n; wh0 = w_hs_n;
    aw_lat = 3;
    send_cmd(1'b1, 5'h08, 32'd197, 4'hF, 50, lat);
    aw_lat = 1;
    vectors++; if (lat <= 0) begin miscompares++; $display("FAIL wr_delay_rsp: got latency %0d expected a response", lat); end
    vectors++; if (aw_hi - a0 !== 3) begin miscompares++; $display("FAIL wr_delay_awvalid_cycles: got %0d expected 3", aw_hi - a0); end
    vectors++; if (w_hi - w0 !== 1) begin miscompares++; $display("FAIL wr_delay_wvalid_cycles: got %0d expected 1", w_hi - w0); end
    vectors++; if (aw_hs_n - ah0 !== 1) begin miscompares++; $display("FAIL wr_delay_aw_hs: got %0d expected 1", aw_hs_n - ah0); end
    vectors++; if (w_hs_n - wh0 !== 1) begin miscompares++; $display("FAIL wr_delay_w_hs: got %0d expected 1", w_hs_n - wh0); end
    vectors++; if (regs[2] !== 32'd197) begin miscompares++; $display("FAIL wr_delay_slave_reg: got %0d expected 197", regs[2]); end
    vectors++; if ({rsp_resp, rsp_is_read, rsp_rdata} !== 35'h0) begin
      miscompares++; $display("FAIL wr_delay_rsp_fields: got %h expected 0", {rsp_resp, rsp_is_read, rsp_rdata}); end
    consume_rsp();
  endtask

  task automatic test_bresp_backpressure();
    int lat;
    b_resp_cfg = 2'b10;
    send_cmd(1'b1, 5'h04, 32'h1, 4'hF, 50, lat);
    b_resp_cfg = 2'b00;
    vectors++; if (lat <= 0) begin miscompares++; $display("FAIL bp_rsp: got latency %0d expected a response", lat); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL bp_rsp_valid[%0d]: got %b expected 1", k, rsp_valid); end
      vectors++; if (rsp_resp !== 2'b10) begin miscompares++; $display("FAIL bp_rsp_resp[%0d]: got %b expected 10", k, rsp_resp); end
      vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL bp_cmd_ready[%0d]: got %b expected 0", k, cmd_ready); end
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL bp_cmd_ready_after: got %b expected 1", cmd_ready); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL bp_rsp_valid_after: got %b expected 0", rsp_valid); end
    vectors++; if (regs[1] !== 32'h1) begin miscompares++; $display("FAIL bp_slave_reg: got %h expected 1", regs[1]); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [ADDR_W-1:0] exp_addr [3];
    logic [DATA_W-1:0] exp_data [3];
    exp_addr[0] = 5'h14; exp_addr[1] = 5'h18; exp_addr[2] = 5'h1C;
    exp_data[0] = 32'h100; exp_data[1] = 32'h8; exp_data[2] = 32'hA;
    aw_log.delete();
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_cmd(1'b1, exp_addr[i], exp_data[i], 4'hF, 50, lat);
      vectors++; if (lat <= 0 || rsp_resp !== 2'b00) begin
        miscompares++; $display("FAIL b2b_rsp[%0d]: got latency %0d resp %b expected response with resp 00", i, lat, rsp_resp); end
    end
    @(posedge clk); #1 rsp_ready = 1'b0;
    vectors++; if (regs[5] !== 32'd256) begin miscompares++; $display("FAIL b2b_mult: got %0d expected 256", regs[5]); end
    vectors++; if (regs[6] !== 32'd8) begin miscompares++; $display("FAIL b2b_shift: got %0d expected 8", regs[6]); end
    vectors++; if (regs[7] !== 32'd10) begin miscompares++; $display("FAIL b2b_zp: got %0d expected 10", regs[7]); end
    vectors++; if (aw_log.size() !== 3) begin miscompares++; $display("FAIL b2b_aw_count: got %0d expected 3", aw_log.size()); end
    for (int i = 0; i < 3 && i < aw_log.size(); i++) begin
      vectors++; if (aw_log[i] !== exp_addr[i]) begin
        miscompares++; $display("FAIL b2b_aw_order[%0d]: got %h expected %h", i, aw_log[i], exp_addr[i]); end
    end
  endtask

  task automatic test_reset_mid_read();
    int lat, seen;
    r_hold = 1'b1;
    send_cmd(1'b0, 5'h10, '0, 4'h0, 5, lat);
    vectors++; if (lat !== -1) begin miscompares++; $display("FAIL rst_mid_no_rsp_before: got latency %0d expected none", lat); end
    vectors++; if (axi.rready !== 1'b1) begin miscompares++; $display("FAIL rst_mid_in_rd_data: got rready %b expected 1", axi.rready); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    r_hold = 1'b0;
    @(negedge clk);
    vectors++; if ({axi.arvalid, axi.rready, rsp_valid} !== 3'b000) begin
      miscompares++; $display("FAIL rst_mid_drop: got ar/r/rsp %b expected 000", {axi.arvalid, axi.rready, rsp_valid}); end
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rst_mid_cmd_ready: got %b expected 1", cmd_ready); end
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen++;
    end
    vectors++; if (seen !== 0) begin miscompares++; $display("FAIL rst_mid_no_rsp_after: got %0d rsp cycles expected 0", seen); end
    send_cmd(1'b0, 5'h10, '0, 4'h0, 20, lat);
    vectors++; if (lat !== 4 || rsp_rdata !== 32'h20260116) begin
      miscompares++; $display("FAIL rst_mid_recover: got latency %0d data %h expected 4 20260116", lat, rsp_rdata); end
    consume_rsp();
  endtask

  task automatic test_timeout();
    int lat, a0;
    a0 = ar_hi;
    ar_block = 1'b1;
`ifdef AXIL_MASTER_TIMEOUT_EN
    send_cmd(1'b0, 5'h0C, '0, 4'h0, 100, lat);
    vectors++; if (lat !== 17) begin miscompares++; $display("FAIL to_latency: got %0d expected 17", lat); end
    vectors++; if (ar_hi - a0 !== 16) begin miscompares++; $display("FAIL to_arvalid_cycles: got %0d expected 16", ar_hi - a0); end
    vectors++; if (rsp_timeout !== 1'b1) begin miscompares++; $display("FAIL to_flag: got %b expected 1", rsp_timeout); end
    vectors++; if (rsp_resp !== 2'b10) begin miscompares++; $display("FAIL to_resp: got %b expected 10", rsp_resp); end
    vectors++; if (rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL to_rdata: got %h expected 0", rsp_rdata); end
    vectors++; if ({axi.arvalid, axi.rready} !== 2'b00) begin
      miscompares++; $display("FAIL to_drop: got ar/r %b expected 00", {axi.arvalid, axi.rready}); end
    ar_block = 1'b0;
    consume_rsp();
`else
    send_cmd(1'b0, 5'h0C, '0, 4'h0, 1000, lat);
    vectors++; if (lat !== -1) begin miscompares++; $display("FAIL no_to_rsp: got latency %0d expected none", lat); end
    vectors++; if (axi.arvalid !== 1'b1) begin miscompares++; $display("FAIL no_to_arvalid: got %b expected 1", axi.arvalid); end
    vectors++; if (rsp_timeout !== 1'b0) begin miscompares++; $display("FAIL no_to_flag: got %b expected 0", rsp_timeout); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    ar_block = 1'b0;
`endif
    send_cmd(1'b0, 5'h10, '0, 4'h0, 20, lat);
    vectors++; if (lat !== 4 || rsp_timeout !== 1'b0) begin
      miscompares++; $display("FAIL to_recover: got latency %0d timeout %b expected 4 0", lat, rsp_timeout); end
    consume_rsp();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_aw_delay();
    test_bresp_backpressure();
    test_back_to_back();
    test_reset_mid_read();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- AXI-Lite initiator that turns single-beat commands from an on-chip sequencer into AXI-Lite read and write transactions.
- Used to drive the accelerator's control slave (ap_start, config, PPU registers) from a local microsequencer and for bus-level self-test.
- One outstanding transaction at a time; the result is returned on a response channel with a valid/ready handshake.

Parameters:
- ADDR_W, 5, AXI address width (32-byte register map).
- DATA_W, 32, AXI data width; the strobe width is DATA_W/8.
- TIMEOUT_CYCLES, 256, watchdog limit in cycles; used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  DATA_W  write data
- cmd_wstrb  in  DATA_W/8  write strobes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  read data (0 for writes)
- rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout
- rsp_is_read  out  1  response belongs to a read
- rsp_timeout  out  1  transaction aborted by the watchdog
- m_axi_awaddr/awvalid/awready, m_axi_wdata/wstrb/wvalid/wready, m_axi_bresp/bvalid/bready, m_axi_araddr/arvalid/arready, m_axi_rdata/rresp/rvalid/rready: standard AXI-Lite master directions and widths

Behaviour:
- Reset (sync, active-high): state IDLE. All m_axi_*valid, bready, rready and rsp_valid = 0; rsp_* data = 0; cmd_ready = 1 from the first cycle after reset. Reset mid-transaction drops every valid/ready on the next edge and discards the transaction with no response.
- All AXI and rsp outputs are registered.
- States: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE:
  - cmd_ready = 1; the command is latched on handshake.
  - Write: the next cycle awvalid = wvalid = 1 and the state goes to WR.
  - Read: the next cycle arvalid = 1 and the state goes to RD_ADDR.
- WR:
  - aw_done and w_done flags track the two handshakes independently.
  - awvalid drops on the edge after awvalid & awready; wvalid drops on the edge after wvalid & wready.
  - Same-cycle and differently-timed AW/W acceptance are both legal.
  - Once both flags are set, bready = 1 and the state goes to WR_RESP.
  - Address and data are never re-presented after their handshake.
- WR_RESP: on bvalid & bready, capture bresp, drop bready, rsp_is_read = 0, rsp_rdata = 0, go to RSP.
- RD_ADDR: on arvalid & arready, drop arvalid, set rready = 1, go to RD_DATA.
- RD_DATA: on rvalid & rready, capture rdata and rresp, drop rready, rsp_is_read = 1, go to RSP.
- RSP:
  - rsp_valid = 1, with rsp fields held stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE; cmd_ready rises the next cycle.
- AXI valids never deassert before their handshake; the payload is stable while valid.
- Best-case latency with a zero-wait slave:
  - Write: cmd handshake at cycle 0; aw/w handshake at cycle 1; bready at cycle 2; B handshake at cycle ≥3; rsp_valid asserted one cycle after the B handshake.
  - Read: rsp_valid asserted 4 cycles after the cmd handshake.
- A new command presented while rsp_valid is pending is stalled (cmd_ready = 0).

Optional Feature:
- Macro AXIL_MASTER_TIMEOUT_EN.
- When defined:
  - A counter clears on entering WR/RD_ADDR and increments every cycle in WR, WR_RESP, RD_ADDR, RD_DATA.
  - When it reaches TIMEOUT_CYCLES, all m_axi valids/readies drop on the next edge and the state goes to RSP with rsp_timeout = 1, rsp_resp = 2'b10, rsp_rdata = 0.
  - Responses arriving later are ignored: bready and rready stay 0 until a new transaction asserts them.
- When undefined: no counter is built, the block waits indefinitely, and rsp_timeout is tied to 0.

Test Plan:
- Read 0x10 from a zero-wait slave returning 0x20260116 -> rsp_valid exactly 4 cycles after the cmd handshake; rsp_rdata = 0x20260116, rsp_resp = 0, rsp_is_read = 1.
- Write 0x08 = 197 with awready delayed 3 cycles and wready immediate -> wvalid drops after 1 cycle, awvalid is held for 3 cycles, exactly one AW and one W handshake; slave register = 197; rsp_resp = 0.
- Write 0x04 = 0x1 with the slave returning BRESP = 2'b10 and rsp_ready held low for 5 cycles -> rsp_valid and rsp_resp = 2'b10 stable for all 5 cycles; cmd_ready = 0 throughout; cmd_ready = 1 the cycle after rsp_ready.
- Assert rst for 1 cycle while in RD_DATA (rvalid low) -> next cycle arvalid = rready = rsp_valid = 0, cmd_ready = 1; no response is emitted.
- With AXIL_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES = 16, read a slave that never asserts arready -> arvalid drops after 16 cycles; rsp_timeout = 1, rsp_resp = 2'b10. Without the macro, arvalid is still high after 1000 cycles.
- Back-to-back writes 0x14 = 0x100, 0x18 = 0x8, 0x1C = 0xA with rsp_ready tied high -> three ordered transactions, slave mult/shift/zp = 256/8/10, no overlap of AW phases.
